// File: rtl/sipo_stream_collector.sv
// sipo_stream_collector
//
// Collects a multi-beat serial stream (header plus one data word per beat) into
// one wide parallel message for a single-beat consumer. The final word of each
// message is not registered: it passes straight from data_i to its slot in
// data_o, so v_o rises in the same cycle as the final input beat. A stalled
// final beat therefore relies on the producer holding its inputs stable.
//
// Parameters:
//   width_p        width of one serial data word
//   max_els_p      maximum words per message (>= 2)
//   header_width_p header width
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   header_i              stream header, meaningful on the first beat
//   data_i, v_i, last_i   serial word, beat valid, final-beat marker
//   len_i                 words minus one, sampled on the first beat
//   ready_and_o           beat accepted when v_i & ready_and_o
//   header_o              header of the message being assembled
//   data_o, v_o           assembled message (word 0 in LSBs) and its valid
//   ready_and_i           consumer ready
//   first_o               next accepted beat is word 0
//   streaming_o           streaming-state flag
//
// Optional build macro: SIPO_STREAM_CHECKS_EN enables simulation-only protocol
// checks. Datapath behaviour is the same with or without it.

module sipo_stream_collector #(
  parameter int unsigned width_p        = 64,
  parameter int unsigned max_els_p      = 4,
  parameter int unsigned header_width_p = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [header_width_p-1:0]       header_i,
  input  logic [width_p-1:0]              data_i,
  input  logic                            v_i,
  input  logic                            last_i,
  input  logic [$clog2(max_els_p)-1:0]    len_i,
  output logic                            ready_and_o,
  output logic [header_width_p-1:0]       header_o,
  output logic [max_els_p*width_p-1:0]    data_o,
  output logic                            v_o,
  input  logic                            ready_and_i,
  output logic                            first_o,
  output logic                            streaming_o
);

  localparam int unsigned lg_els_lp = $clog2(max_els_p);

  logic [lg_els_lp-1:0]      r_count;
  logic [lg_els_lp-1:0]      r_len;
  logic                      r_streaming;
  logic [header_width_p-1:0] r_header;
  logic [width_p-1:0]        r_data [max_els_p];

  logic [lg_els_lp-1:0]      w_eff_len;
  logic                      w_final;
  logic                      w_accept;
  logic                      w_clear;

  // Framing: the message length comes from len_i on word 0 and from the
  // latched copy afterwards, so a changing len_i mid-message is ignored.
  always_comb begin
    w_eff_len   = (r_count == '0) ? len_i : r_len;
    w_final     = (r_count == w_eff_len);
    ready_and_o = w_final ? ready_and_i : 1'b1;
    v_o         = w_final & v_i;
    w_accept    = v_i & ready_and_o;
    w_clear     = last_i & v_o & ready_and_i;
  end

  // Output assembly: captured words below count, live data_i at count,
  // zeros above it.
  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < max_els_p; k++) begin
      if (k == 32'(r_count))
        data_o[k*width_p +: width_p] = data_i;
      else if (k < 32'(r_count))
        data_o[k*width_p +: width_p] = r_data[k];
    end
  end

  always_comb begin
    header_o    = r_streaming ? r_header : header_i;
    first_o     = (r_count == '0);
    streaming_o = r_streaming;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count     <= '0;
      r_len       <= '0;
      r_streaming <= 1'b0;
      r_header    <= '0;
      for (int unsigned i = 0; i < max_els_p; i++)
        r_data[i] <= '0;
    end else begin
      // Header tracks the input until a stream starts, then freezes.
      if (!r_streaming)
        r_header <= header_i;

      // Clear has priority over set.
      if (w_clear)
        r_streaming <= 1'b0;
      else if (v_i)
        r_streaming <= 1'b1;

      if (w_accept && (r_count == '0))
        r_len <= len_i;

      if (v_i) begin
        if (!w_final) begin
          r_data[r_count] <= data_i;
          r_count         <= r_count + lg_els_lp'(1);
        end else if (ready_and_i) begin
          r_count <= '0;
        end
      end
    end
  end

`ifdef SIPO_STREAM_CHECKS_EN
  logic r_chk_stall;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_chk_stall <= 1'b0;
    end else begin
      if (v_i && first_o && (32'(len_i) > max_els_p - 1))
        $error("sipo_stream_collector: len_i %0d exceeds max_els_p-1", len_i);
      if (v_i && (last_i != w_final))
        $error("sipo_stream_collector: last_i=%0b disagrees with framing", last_i);
      if (r_chk_stall && !v_i)
        $error("sipo_stream_collector: v_i dropped during final-beat stall");
      r_chk_stall <= v_o & ~ready_and_i;
    end
  end
`endif

endmodule

// File: tb/tb_sipo_stream_collector.sv
module tb_sipo_stream_collector;

  localparam int unsigned W  = 8;
  localparam int unsigned M  = 4;
  localparam int unsigned HW = 32;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [HW-1:0]   header_i;
  logic [W-1:0]    data_i;
  logic            v_i;
  logic            last_i;
  logic [1:0]      len_i;
  logic            ready_and_o;
  logic [HW-1:0]   header_o;
  logic [M*W-1:0]  data_o;
  logic            v_o;
  logic            ready_and_i;
  logic            first_o;
  logic            streaming_o;

  int n_checks = 0;
  int n_fail   = 0;

  sipo_stream_collector #(
    .width_p        (W),
    .max_els_p      (M),
    .header_width_p (HW)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .header_i    (header_i),
    .data_i      (data_i),
    .v_i         (v_i),
    .last_i      (last_i),
    .len_i       (len_i),
    .ready_and_o (ready_and_o),
    .header_o    (header_o),
    .data_o      (data_o),
    .v_o         (v_o),
    .ready_and_i (ready_and_i),
    .first_o     (first_o),
    .streaming_o (streaming_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    v_i = 1'b0; last_i = 1'b0; len_i = 2'd0; data_i = '0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; ready_and_i = 1'b1; header_i = 32'h0; idle();
    tick();
    reset_i = 1'b0;
    #4;
    n_checks++; if (v_o !== 1'b0) begin $display("FAIL reset_v_o: got %b want 0", v_o); n_fail++; end
    n_checks++; if (first_o !== 1'b1) begin $display("FAIL reset_first_o: got %b want 1", first_o); n_fail++; end
    n_checks++; if (streaming_o !== 1'b0) begin $display("FAIL reset_streaming_o: got %b want 0", streaming_o); n_fail++; end
    tick();
    // two of four words, then asynchronous reset mid-message
    v_i = 1'b1; len_i = 2'd3; data_i = 8'h01;
    tick();
    data_i = 8'h02;
    tick();
    reset_i = 1'b1; data_i = 8'h03;
    #2;
    n_checks++; if (v_o !== 1'b0) begin $display("FAIL midrst_v_o: got %b want 0", v_o); n_fail++; end
    n_checks++; if (first_o !== 1'b1) begin $display("FAIL midrst_first_o: got %b want 1", first_o); n_fail++; end
    n_checks++; if (streaming_o !== 1'b0) begin $display("FAIL midrst_streaming_o: got %b want 0", streaming_o); n_fail++; end
    reset_i = 1'b0; len_i = 2'd0; data_i = 8'hAB; last_i = 1'b1;
    #2;
    n_checks++; if (v_o !== 1'b1) begin $display("FAIL postrst_v_o: got %b want 1", v_o); n_fail++; end
    n_checks++; if (data_o !== 32'h0000_00AB) begin $display("FAIL postrst_data_o: got %h want 000000ab", data_o); n_fail++; end
    tick();
    idle();
    #4;
    n_checks++; if (streaming_o !== 1'b0) begin $display("FAIL postrst_stream_clr: got %b want 0", streaming_o); n_fail++; end
    tick();
  endtask

  task automatic test_four_word();
    logic [W-1:0] d [4];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    ready_and_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; len_i = 2'd3; data_i = d[i]; last_i = (i == 3);
      #4;
      n_checks++; if (v_o !== (i == 3)) begin $display("FAIL four_v_o[%0d]: got %b want %b", i, v_o, (i == 3)); n_fail++; end
      n_checks++; if (ready_and_o !== 1'b1) begin $display("FAIL four_ready[%0d]: got %b want 1", i, ready_and_o); n_fail++; end
      n_checks++; if (first_o !== (i == 0)) begin $display("FAIL four_first[%0d]: got %b want %b", i, first_o, (i == 0)); n_fail++; end
      if (i == 1) begin
        n_checks++; if (streaming_o !== 1'b1) begin $display("FAIL four_streaming: got %b want 1", streaming_o); n_fail++; end
      end
      if (i == 3) begin
        n_checks++; if (data_o !== 32'h4433_2211) begin $display("FAIL four_data_o: got %h want 44332211", data_o); n_fail++; end
      end
      tick();
    end
    idle();
    #4;
    n_checks++; if (streaming_o !== 1'b0) begin $display("FAIL four_stream_clr: got %b want 0", streaming_o); n_fail++; end
    n_checks++; if (first_o !== 1'b1) begin $display("FAIL four_first_after: got %b want 1", first_o); n_fail++; end
    tick();
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b1; len_i = 2'd0; data_i = 8'h5A; last_i = 1'b1;
      ready_and_i = (i == 3);
      #4;
      n_checks++; if (v_o !== 1'b1) begin $display("FAIL single_v_o[%0d]: got %b want 1", i, v_o); n_fail++; end
      n_checks++; if (ready_and_o !== (i == 3)) begin $display("FAIL single_ready[%0d]: got %b want %b", i, ready_and_o, (i == 3)); n_fail++; end
      n_checks++; if (data_o !== 32'h0000_005A) begin $display("FAIL single_data_o[%0d]: got %h want 0000005a", i, data_o); n_fail++; end
      if (i == 1) begin
        n_checks++; if (streaming_o !== 1'b1) begin $display("FAIL single_streaming: got %b want 1", streaming_o); n_fail++; end
      end
      tick();
    end
    idle(); ready_and_i = 1'b1;
    #4;
    n_checks++; if (streaming_o !== 1'b0) begin $display("FAIL single_stream_clr: got %b want 0", streaming_o); n_fail++; end
    n_checks++; if (first_o !== 1'b1) begin $display("FAIL single_first_after: got %b want 1", first_o); n_fail++; end
    tick();
  endtask

  task automatic test_header();
    logic [W-1:0] d [3];
    d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03;
    ready_and_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1; len_i = 2'd2; data_i = d[i]; last_i = (i == 2);
      header_i = (i == 0) ? 32'h0000_CAFE : 32'h0000_BEEF;
      #4;
      n_checks++; if (header_o !== 32'h0000_CAFE) begin $display("FAIL hdr_header_o[%0d]: got %h want 0000cafe", i, header_o); n_fail++; end
      if (i == 2) begin
        n_checks++; if (v_o !== 1'b1) begin $display("FAIL hdr_v_o: got %b want 1", v_o); n_fail++; end
        n_checks++; if (data_o !== 32'h0003_0201) begin $display("FAIL hdr_data_o: got %h want 00030201", data_o); n_fail++; end
      end
      tick();
    end
    idle(); header_i = 32'h0000_1234;
    #4;
    n_checks++; if (streaming_o !== 1'b0) begin $display("FAIL hdr_stream_clr: got %b want 0", streaming_o); n_fail++; end
    n_checks++; if (header_o !== 32'h0000_1234) begin $display("FAIL hdr_bypass: got %h want 00001234", header_o); n_fail++; end
    tick();
  endtask

  task automatic test_len_latch();
    ready_and_i = 1'b1;
    v_i = 1'b1; len_i = 2'd1; data_i = 8'h10; last_i = 1'b0;
    #4;
    n_checks++; if (v_o !== 1'b0) begin $display("FAIL latch_v_o0: got %b want 0", v_o); n_fail++; end
    tick();
    len_i = 2'd3; data_i = 8'h20; last_i = 1'b1;
    #4;
    n_checks++; if (v_o !== 1'b1) begin $display("FAIL latch_v_o1: got %b want 1", v_o); n_fail++; end
    n_checks++; if (data_o !== 32'h0000_2010) begin $display("FAIL latch_data_o: got %h want 00002010", data_o); n_fail++; end
    tick();
    idle();
    #4;
    n_checks++; if (first_o !== 1'b1) begin $display("FAIL latch_first_after: got %b want 1", first_o); n_fail++; end
    tick();
  endtask

  task automatic test_back_to_back();
    ready_and_i = 1'b1;
    v_i = 1'b1; len_i = 2'd1; data_i = 8'hA1; last_i = 1'b0;
    #4;
    n_checks++; if (v_o !== 1'b0) begin $display("FAIL b2b_v_o_c1: got %b want 0", v_o); n_fail++; end
    tick();
    data_i = 8'hA2; last_i = 1'b1;
    #4;
    n_checks++; if (v_o !== 1'b1) begin $display("FAIL b2b_v_o_c2: got %b want 1", v_o); n_fail++; end
    n_checks++; if (data_o !== 32'h0000_A2A1) begin $display("FAIL b2b_data_c2: got %h want 0000a2a1", data_o); n_fail++; end
    tick();
    len_i = 2'd0; data_i = 8'hB1; last_i = 1'b1;
    #4;
    n_checks++; if (v_o !== 1'b1) begin $display("FAIL b2b_v_o_c3: got %b want 1", v_o); n_fail++; end
    n_checks++; if (ready_and_o !== 1'b1) begin $display("FAIL b2b_ready_c3: got %b want 1", ready_and_o); n_fail++; end
    n_checks++; if (data_o !== 32'h0000_00B1) begin $display("FAIL b2b_data_c3: got %h want 000000b1", data_o); n_fail++; end
    tick();
    idle();
    #4;
    n_checks++; if (v_o !== 1'b0) begin $display("FAIL b2b_v_o_idle: got %b want 0", v_o); n_fail++; end
    tick();
  endtask

  initial begin
    test_reset();
    test_four_word();
    test_single();
    test_header();
    test_len_latch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
